// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: operand forwarding and load-use hazard control for the integer pipeline.
// Latency: ex_fwd_sel is registered on each advance, so it is valid in the cycle the consumer sits in EX.
//          id_stall is combinational from the EX-stage entry, with no registered delay.
// Backpressure: pipe_hold freezes every entry and every select. id_stall makes the ID stage hold
//               while a bubble is issued into EX.
//
// Ports:
//   clk, rst       pipeline clock; synchronous active-high reset, which overrides hold and flush
//   pipe_hold      global stall; all state freezes
//   flush          squash the instruction in ID
//   id_valid       ID holds a real instruction
//   id_src_addr    NUM_SRC packed source addresses; source i is at [i*REG_AW +: REG_AW]
//   id_dst_addr    destination register of the instruction in ID
//   id_reg_write   the instruction in ID writes id_dst_addr
//   id_is_load     the result of the instruction in ID is ready only at the end of MEM
//   id_stall       load-use hazard against the instruction in EX
//   ex_fwd_sel     per-source select; 0 = register file, k = result held in stage k
//   stat_stall_cnt, stat_fwd_cnt  saturating event counters (only with FWD_SCOREBOARD_STATS_EN)
//
// Optional build macro: FWD_SCOREBOARD_STATS_EN adds the two statistics counters.
module fwd_scoreboard #(
  parameter int REG_AW  = 3,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  localparam int SEL_W  = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pipe_hold,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [REG_AW-1:0]         id_dst_addr,
  input  logic                      id_reg_write,
  input  logic                      id_is_load,
  output logic                      id_stall,
  output logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel
`ifdef FWD_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]               stat_stall_cnt,
  output logic [31:0]               stat_fwd_cnt
`endif
);

  // The entry in the last tracked stage can never be a forwarding candidate: the
  // candidate for select k is the entry currently in stage k-1, so k <= DEPTH-1 only
  // ever looks at stages 0..DEPTH-2. Only those stages are kept in flops. The load
  // flag matters only in EX, which is where load-use is detected, so only stage 0
  // keeps it.
  localparam int NS = DEPTH - 1;

  logic [NS-1:0]             st_vld;
  logic [NS-1:0]             st_wr;
  logic [NS-1:0][REG_AW-1:0] st_dst;
  logic                      st0_ld;

  logic [NUM_SRC-1:0][SEL_W-1:0]  sel_q;
  logic [NUM_SRC-1:0][SEL_W-1:0]  sel_nxt;
  logic [NUM_SRC-1:0][REG_AW-1:0] src;
  logic [NUM_SRC-1:0][NS-1:0]     hit;
  logic                           ld_hit;
  logic                           issue;

  assign src        = id_src_addr;
  assign ex_fwd_sel = sel_q;

  // hit[i][k] is set when stage k writes source i. Register 0 never matches.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < NS; k++) begin
        hit[i][k] = st_vld[k] && st_wr[k] && (st_dst[k] == src[i]) && (src[i] != '0);
      end
    end
  end

  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (hit[i][0] && st0_ld) begin
        ld_hit = 1'b1;
      end
    end
  end

  assign id_stall = id_valid && !flush && ld_hit;
  assign issue    = id_valid && !id_stall && !flush;

  // A producer now in stage k-1 will be in stage k when the consumer reaches EX.
  // The loop scans from the oldest candidate to the youngest, so the youngest
  // matching producer (the smallest k) overwrites any older match.
  always_comb begin
    sel_nxt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NS; k >= 1; k--) begin
        if (hit[i][k-1]) begin
          sel_nxt[i] = SEL_W'(k);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_vld <= '0;
      st_wr  <= '0;
      st_dst <= '0;
      st0_ld <= 1'b0;
      sel_q  <= '0;
    end else if (!pipe_hold) begin
      for (int k = 1; k < NS; k++) begin
        st_vld[k] <= st_vld[k-1];
        st_wr[k]  <= st_wr[k-1];
        st_dst[k] <= st_dst[k-1];
      end
      if (issue) begin
        st_vld[0] <= 1'b1;
        st_wr[0]  <= id_reg_write;
        st_dst[0] <= id_dst_addr;
        st0_ld    <= id_is_load;
        sel_q     <= sel_nxt;
      end else begin
        // A stall or flush puts a bubble into EX, and that bubble reads nothing.
        st_vld[0] <= 1'b0;
        st_wr[0]  <= 1'b0;
        st_dst[0] <= '0;
        st0_ld    <= 1'b0;
        sel_q     <= '0;
      end
    end
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  logic fwd_any;

  // Non-zero selects come only from issued instructions, so gating with issue
  // counts exactly the advances that load a non-zero select.
  assign fwd_any = issue && (sel_nxt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_cnt <= '0;
      stat_fwd_cnt   <= '0;
    end else begin
      if (id_stall && !pipe_hold && (stat_stall_cnt != 32'hFFFF_FFFF)) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
      if (fwd_any && !pipe_hold && (stat_fwd_cnt != 32'hFFFF_FFFF)) begin
        stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
